axis_fifo_sync: RTL and testbench
=================================

Name: axis_fifo_sync

Overview:
- Synchronous first-word-fall-through AXI-Stream FIFO that sits directly downstream of the 2-to-1 stream mux.
- Consumes the mux output stream (mi_*) on its slave side and presents a buffered stream (mo_*) to the next processing element.
- Decouples mux tready from downstream backpressure, and absorbs bursts while the mux CONF is stable.
- FLUSH input lets the controller discard stale words when CONF is switched.

Parameters:
- DWIDTH, 32, data width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- AWIDTH, 3, log2(DEPTH); pointer width.

Ports:
- ACLK  input  1  clock; all state updates on rising edge.
- ARESET  input  1  asynchronous active-high reset.
- FLUSH  input  1  synchronous clear of contents; active-high, single-cycle pulse or level.
- si_tready  output  1  FIFO can accept a word.
- si_tvalid  input  1  upstream word valid.
- si_tdata  input  DWIDTH  upstream word.
- mo_tready  input  1  downstream accepts.
- mo_tvalid  output  1  FIFO holds at least one word.
- mo_tdata  output  DWIDTH  head word.
- count  output  AWIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- State: storage array mem[DEPTH], wr_ptr and rd_ptr (AWIDTH bits, wrap modulo DEPTH), and count register (AWIDTH+1 bits).
- push = si_tvalid & si_tready; pop = mo_tvalid & mo_tready.
- si_tready = ~full & ~ARESET.
  - Combinational from registered count only; never depends on mo_tready.
  - So there is no write-when-full, even when a pop occurs in the same cycle.
- mo_tvalid = ~empty.
- mo_tdata = mem[rd_ptr]: first-word-fall-through, no output register.
- full = (count == DEPTH); empty = (count == 0).
- Reset, asynchronous: while ARESET is high and after its release:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Therefore mo_tvalid = 0, empty = 1, full = 0, si_tready = 0 while ARESET is high and 1 after release.
  - mem contents are not reset; mo_tdata is don't-care while empty.
- Push only: mem[wr_ptr] <= si_tdata; wr_ptr += 1 (wraps DEPTH-1 -> 0); count += 1.
- Pop only: rd_ptr += 1 (wraps); count -= 1.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
  - Legal at any count 1..DEPTH-1.
  - At count 0 no pop is possible (mo_tvalid=0).
  - At count DEPTH no push is possible (si_tready=0).
- Latency: a word pushed at edge N is visible on mo_tdata with mo_tvalid=1 after edge N; minimum one-cycle fall-through.
  - There is no combinational si->mo bypass when empty.
- Throughput: one word per cycle sustained when both sides are ready and 0 < count < DEPTH.
- Ordering: strict FIFO; no reordering, duplication or loss.
- FLUSH, sampled at the clock edge:
  - Sets wr_ptr = rd_ptr = 0 and count = 0.
  - Overrides any push or pop in the same cycle; the concurrent word is dropped.
  - si_tready stays as computed from count, so an upstream word offered in the FLUSH cycle is consumed and discarded.
- Once mo_tvalid is asserted, mo_tvalid and mo_tdata hold stable until a pop, FLUSH or ARESET (AXIS rule).
- ARESET asserted mid-transfer immediately drops mo_tvalid and si_tready; no partial state is retained.

Test Plan:
- Reset release, then push 0x00000001..0x00000008 with mo_tready=0:
  - count steps 1..8; full=1 after the 8th push; si_tready=0.
  - A 9th word 0x000000FF held on si stays unaccepted.
- From full, raise mo_tready=1 for 8 cycles:
  - mo_tdata reads 0x01..0x08 in order; count returns to 0; empty=1; mo_tvalid=0.
- Continuous stream 0xA0000000+i, i=0..31, with mo_tready=1 throughout:
  - First word appears one cycle after its push; then one word per cycle.
  - count stays at 1; pointers wrap four times with no loss.
- Random mo_tready (50%) and si_tvalid (70%), 1000 words:
  - Scoreboard matches the output sequence exactly.
  - mo_tdata is stable whenever mo_tvalid=1 and mo_tready=0.
- Fill with 5 words, then pulse FLUSH together with si_tvalid=1 (data 0xDEAD) and mo_tready=1:
  - Next cycle count=0, empty=1; 0xDEAD never appears on mo.
  - A subsequent push of 0xBEEF is output first.
- With 3 words held, assert ARESET asynchronously between clock edges:
  - mo_tvalid and si_tready drop without waiting for a clock.
  - After release count=0 and the old words never appear.

Source files
------------

// File: rtl/axis_fifo_sync.sv
// Synchronous first-word-fall-through AXI-Stream FIFO placed after the 2-to-1 stream mux.
// Buffers the mux output, isolates its tready from downstream backpressure, and supports a synchronous FLUSH.
module axis_fifo_sync #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 3
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              FLUSH,
  output logic              si_tready,
  input  logic              si_tvalid,
  input  logic [DWIDTH-1:0] si_tdata,
  input  logic              mo_tready,
  output logic              mo_tvalid,
  output logic [DWIDTH-1:0] mo_tdata,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [AWIDTH:0]   DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              push, pop;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high.
  // si_tready depends only on the registered count, so a full FIFO never accepts a
  // word even if the head is being popped in the same cycle.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign si_tready = ~full & ~ARESET;
  assign mo_tvalid = ~empty;
  assign mo_tdata  = mem_q[rd_ptr_q];

  assign push = si_tvalid & si_tready;
  assign pop  = mo_tvalid & mo_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left unreset; contents are only observed while non-empty.
  always_ff @(posedge ACLK) begin
    if (push && !FLUSH) mem_q[wr_ptr_q] <= si_tdata;
  end

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Self-checking bench for axis_fifo_sync: a reference occupancy model plus an expected-data queue
// drive every check; outputs are sampled on the falling clock edge.
module tb_axis_fifo_sync;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 8;
  localparam int AWIDTH = 3;

  logic              ACLK;
  logic              ARESET;
  logic              FLUSH;
  logic              si_tready;
  logic              si_tvalid;
  logic [DWIDTH-1:0] si_tdata;
  logic              mo_tready;
  logic              mo_tvalid;
  logic [DWIDTH-1:0] mo_tdata;
  logic [AWIDTH:0]   count;
  logic              full;
  logic              empty;

  axis_fifo_sync #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .FLUSH     (FLUSH),
    .si_tready (si_tready),
    .si_tvalid (si_tvalid),
    .si_tdata  (si_tdata),
    .mo_tready (mo_tready),
    .mo_tvalid (mo_tvalid),
    .mo_tdata  (mo_tdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // scoreboard state
  logic [DWIDTH-1:0] exp_q[$];
  int                m_cnt;
  int                n_cmp;
  int                n_err;
  logic              stall_prev;
  logic [DWIDTH-1:0] data_prev;

  task automatic check_val(input string tag, input logic [DWIDTH-1:0] obs,
                           input logic [DWIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model on the falling
  // edge, then advance the model on the rising edge.
  task automatic cycle(input logic v, input logic [DWIDTH-1:0] d, input logic r,
                       input logic f);
    logic push_m, pop_m;
    si_tvalid = v;
    si_tdata  = d;
    mo_tready = r;
    FLUSH     = f;
    @(negedge ACLK);
    check_val("count", DWIDTH'(count), DWIDTH'(m_cnt));
    check_val("tready", DWIDTH'(si_tready), DWIDTH'(m_cnt < DEPTH));
    check_val("tvalid", DWIDTH'(mo_tvalid), DWIDTH'(m_cnt > 0));
    check_val("full", DWIDTH'(full), DWIDTH'(m_cnt == DEPTH));
    check_val("empty", DWIDTH'(empty), DWIDTH'(m_cnt == 0));
    if (m_cnt > 0) begin
      if (exp_q.size() == 0) check_val("sb_underrun", 32'd1, 32'd0);
      else check_val("head", mo_tdata, exp_q[0]);
    end
    if (stall_prev && mo_tvalid) check_val("stable", mo_tdata, data_prev);
    stall_prev = mo_tvalid && !r && !f;
    data_prev  = mo_tdata;
    @(posedge ACLK);
    push_m = v && (m_cnt < DEPTH);
    pop_m  = r && (m_cnt > 0);
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (pop_m && exp_q.size() > 0) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(d);
      m_cnt = m_cnt + int'(push_m) - int'(pop_m);
    end
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && m_cnt > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("drained", DWIDTH'(m_cnt), 32'd0);
  endtask

  initial begin
    int pushed;
    int cyc;
    n_cmp = 0;
    n_err = 0;
    m_cnt = 0;
    stall_prev = 1'b0;
    data_prev  = '0;
    ARESET    = 1'b1;
    FLUSH     = 1'b0;
    si_tvalid = 1'b0;
    si_tdata  = '0;
    mo_tready = 1'b0;

    // reset state while asserted
    repeat (2) @(posedge ACLK);
    #2;
    check_val("rst_tready", DWIDTH'(si_tready), 32'd0);
    check_val("rst_tvalid", DWIDTH'(mo_tvalid), 32'd0);
    check_val("rst_empty", DWIDTH'(empty), 32'd1);
    check_val("rst_full", DWIDTH'(full), 32'd0);
    check_val("rst_count", DWIDTH'(count), 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // fill to full, then offer a 9th word that must not be accepted
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DWIDTH'(i), 1'b0, 1'b0);
    check_val("fill_full", DWIDTH'(full), 32'd1);
    cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    // drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("drain_empty", DWIDTH'(empty), 32'd1);

    // continuous stream, both sides ready
    for (int i = 0; i < 32; i++) cycle(1'b1, 32'hA000_0000 + DWIDTH'(i), 1'b1, 1'b0);
    check_val("stream_count", DWIDTH'(count), 32'd1);
    drain(4);

    // random traffic
    pushed = 0;
    cyc    = 0;
    while (pushed < 1000 && cyc < 6000) begin
      logic v, r;
      logic [DWIDTH-1:0] d;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (v && m_cnt < DEPTH) pushed++;
      cycle(v, d, r, 1'b0);
      cyc++;
    end
    check_val("random_budget", DWIDTH'(pushed >= 1000), 32'd1);
    drain(2 * DEPTH);

    // flush overrides a concurrent push and pop
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_1000 + DWIDTH'(i), 1'b0, 1'b0);
    check_val("pre_flush_count", DWIDTH'(count), 32'd5);
    cycle(1'b1, 32'h0000_DEAD, 1'b1, 1'b1);
    check_val("flush_count", DWIDTH'(count), 32'd0);
    check_val("flush_empty", DWIDTH'(empty), 32'd1);
    cycle(1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    check_val("post_flush_head", mo_tdata, 32'h0000_BEEF);
    drain(4);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_3000 + DWIDTH'(i), 1'b0, 1'b0);
    si_tvalid = 1'b0;
    #2;
    ARESET = 1'b1;
    #1;
    check_val("arst_tvalid", DWIDTH'(mo_tvalid), 32'd0);
    check_val("arst_tready", DWIDTH'(si_tready), 32'd0);
    check_val("arst_count", DWIDTH'(count), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    stall_prev = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_7777, 1'b0, 1'b0);
    check_val("post_rst_head", mo_tdata, 32'h0000_7777);
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
